// File: rtl/nco_phase_gen_2ch.sv
// Two-channel NCO phase generator: shared accumulator drives channel A,
// channel B adds a programmable offset; config is double-buffered.
// Ports: i_clk, i_rst (sync, active-high), i_en (clock enable),
//   i_cfg_valid/o_cfg_ready handshake carrying i_cfg_ftw, i_cfg_offset, i_cfg_sync;
//   o_phase_a/o_phase_b phase words, o_wrap carry pulse, o_apply commit pulse.
module nco_phase_gen_2ch #(
    parameter int unsigned          ACC_WIDTH = 24,
    parameter int unsigned          P_WIDTH   = 13,
    parameter logic [ACC_WIDTH-1:0] RESET_FTW = ACC_WIDTH'(2**20)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_cfg_valid,
    output logic                 o_cfg_ready,
    input  logic [ACC_WIDTH-1:0] i_cfg_ftw,
    input  logic [P_WIDTH-1:0]   i_cfg_offset,
    input  logic                 i_cfg_sync,
    output logic [P_WIDTH-1:0]   o_phase_a,
    output logic [P_WIDTH-1:0]   o_phase_b,
    output logic                 o_wrap,
    output logic                 o_apply
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_e;

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] ftw_q, ftw_d;
    logic [ACC_WIDTH-1:0] pftw_q, pftw_d;
    logic [P_WIDTH-1:0]   off_q, off_d;
    logic [P_WIDTH-1:0]   poff_q, poff_d;
    logic                 psync_q, psync_d;
    logic [P_WIDTH-1:0]   pa_q, pa_d;
    logic [P_WIDTH-1:0]   pb_q, pb_d;
    logic                 wrap_q, wrap_d;
    logic                 apply_q, apply_d;

    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic [P_WIDTH-1:0]   top_next;
    logic                 accept;
    logic                 commit;

    assign sum      = {1'b0, acc_q} + {1'b0, ftw_q};
    assign carry    = sum[ACC_WIDTH];
    assign top_next = sum[ACC_WIDTH-1 -: P_WIDTH];
    assign accept   = i_cfg_valid && (state_q == IDLE);
    // A zero tuning word can never wrap, so commit on the next enabled cycle.
    assign commit   = i_en && (state_q == PENDING)
                   && (psync_q || carry || (ftw_q == '0));

    assign o_cfg_ready = (state_q == IDLE);
    assign o_phase_a   = pa_q;
    assign o_phase_b   = pb_q;
    assign o_wrap      = wrap_q;
    assign o_apply     = apply_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = PENDING;
            PENDING: if (commit) state_d = IDLE;
        endcase
    end

    always_comb begin
        acc_d   = acc_q;
        ftw_d   = ftw_q;
        off_d   = off_q;
        pftw_d  = pftw_q;
        poff_d  = poff_q;
        psync_d = psync_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        wrap_d  = 1'b0;
        apply_d = commit;

        if (accept) begin
            pftw_d  = i_cfg_ftw;
            poff_d  = i_cfg_offset;
            psync_d = i_cfg_sync;
        end

        if (i_en) begin
            if (commit && psync_q) begin
                // Phase sync: restart both channels from zero.
                acc_d = '0;
                pa_d  = '0;
                pb_d  = poff_q;
            end else begin
                acc_d  = sum[ACC_WIDTH-1:0];
                pa_d   = top_next;
                // Offset switches in the same cycle as the commit.
                pb_d   = top_next + (commit ? poff_q : off_q);
                wrap_d = carry;
            end
            if (commit) begin
                ftw_d = pftw_q;
                off_d = poff_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ftw_q   <= RESET_FTW;
            off_q   <= '0;
            pftw_q  <= '0;
            poff_q  <= '0;
            psync_q <= 1'b0;
            pa_q    <= '0;
            pb_q    <= '0;
            wrap_q  <= 1'b0;
            apply_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ftw_q   <= ftw_d;
            off_q   <= off_d;
            pftw_q  <= pftw_d;
            poff_q  <= poff_d;
            psync_q <= psync_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            wrap_q  <= wrap_d;
            apply_q <= apply_d;
        end
    end

endmodule

// File: tb/tb_nco_phase_gen_2ch.sv
// Testbench for nco_phase_gen_2ch: vector table, directed corner
// sequences and randomized traffic against an arithmetic reference model.
module tb_nco_phase_gen_2ch;

    localparam longint ACC_MOD = 64'd1 << 24;
    localparam int     P_MOD   = 8192;

    logic        clk;
    logic        rst;
    logic        en;
    logic        valid;
    logic        ready;
    logic [23:0] ftw;
    logic [12:0] off;
    logic        sync;
    logic [12:0] pa;
    logic [12:0] pb;
    logic        wrap;
    logic        apply;

    nco_phase_gen_2ch dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_cfg_valid (valid),
        .o_cfg_ready (ready),
        .i_cfg_ftw   (ftw),
        .i_cfg_offset(off),
        .i_cfg_sync  (sync),
        .o_phase_a   (pa),
        .o_phase_b   (pb),
        .o_wrap      (wrap),
        .o_apply     (apply)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    longint m_acc, m_ftw, p_ftw;
    int     m_off, p_off, m_pa, m_pb;
    bit     m_pend, p_sync, m_wrap, m_apply;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit v,
                         input longint f, input int o, input bit s);
        bit     acc_ok;
        bit     carry;
        bit     cm;
        longint total;
        longint nxt;
        if (r) begin
            m_acc = 0; m_ftw = ACC_MOD / 16; m_off = 0;
            m_pend = 0; m_pa = 0; m_pb = 0; m_wrap = 0; m_apply = 0;
            return;
        end
        acc_ok = v && !m_pend;
        m_wrap = 0;
        m_apply = 0;
        if (e) begin
            total = m_acc + m_ftw;
            carry = total >= ACC_MOD;
            nxt   = total % ACC_MOD;
            cm    = m_pend && (p_sync || carry || m_ftw == 0);
            if (cm && p_sync) begin
                m_acc = 0; m_pa = 0; m_pb = p_off;
            end else begin
                if (cm) m_off = p_off;
                m_acc  = nxt;
                m_pa   = int'(nxt / 2048);
                m_pb   = (m_pa + m_off) % P_MOD;
                m_wrap = carry;
            end
            if (cm) begin
                m_ftw = p_ftw; m_off = p_off; m_pend = 0;
            end
            m_apply = cm;
        end
        if (acc_ok) begin
            p_ftw = f; p_off = o; p_sync = s; m_pend = 1;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit v,
                        input logic [23:0] f, input logic [12:0] o, input bit s);
        rst = r; en = e; valid = v; ftw = f; off = o; sync = s;
        @(posedge clk);
        model(r, e, v, longint'(f), int'(o), s);
        #1;
        chk("model_pa", pa, m_pa);
        chk("model_pb", pb, m_pb);
        chk("model_wrap", wrap, m_wrap);
        chk("model_apply", apply, m_apply);
        chk("model_ready", ready, !m_pend);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit          r, e, v;
        logic [23:0] f;
        logic [12:0] o;
        bit          s;
        int          pa, pb;
        bit          wr, ap, rd;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int     prev;
        int     n;
        bit     seen;
        int     fa, fb;

        rst = 1; en = 0; valid = 0; ftw = 0; off = 0; sync = 0;

        tbl[0] = '{1, 0, 0, 0,        0,    0, 0,    0,    0, 0, 1};
        tbl[1] = '{0, 1, 0, 0,        0,    0, 512,  512,  0, 0, 1};
        tbl[2] = '{0, 1, 0, 0,        0,    0, 1024, 1024, 0, 0, 1};
        tbl[3] = '{0, 1, 1, 24'h100000, 2048, 1, 1536, 1536, 0, 0, 0};
        tbl[4] = '{0, 1, 0, 0,        0,    0, 0,    2048, 0, 1, 1};
        tbl[5] = '{0, 1, 0, 0,        0,    0, 512,  2560, 0, 0, 1};
        tbl[6] = '{0, 0, 0, 0,        0,    0, 512,  2560, 0, 0, 1};
        tbl[7] = '{0, 0, 1, 24'h200000, 0,    0, 512,  2560, 0, 0, 0};
        tbl[8] = '{0, 1, 0, 0,        0,    0, 1024, 3072, 0, 0, 0};

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].f, tbl[i].o, tbl[i].s);
            chk($sformatf("tbl%0d_pa", i), pa, tbl[i].pa);
            chk($sformatf("tbl%0d_pb", i), pb, tbl[i].pb);
            chk($sformatf("tbl%0d_wrap", i), wrap, tbl[i].wr);
            chk($sformatf("tbl%0d_apply", i), apply, tbl[i].ap);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].rd);
        end

        // defaults: +512 per cycle, wrap every 16 cycles back to 0
        step(1, 0, 0, 0, 0, 0);
        n = 0;
        for (int i = 1; i <= 32; i++) begin
            step(0, 1, 0, 0, 0, 0);
            chk("t1_pa", pa, (i * 512) % P_MOD);
            chk("t1_wrap", wrap, (i % 16) == 0);
            if (wrap) n++;
        end
        chk("t1_wrap_count", n, 2);

        // non-sync ftw=2^21 mid-period: commit coincides with wrap
        step(1, 0, 0, 0, 0, 0);
        idle(5);
        step(0, 1, 1, 24'h200000, 0, 0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 1, 0, 0, 0, 0);
            if (apply) seen = 1;
            else chk("t3_ready_low", ready, 0);
        end
        chk("t3_apply_seen", seen, 1);
        chk("t3_apply_with_wrap", wrap, 1);
        chk("t3_pa_at_wrap", pa, 0);
        prev = pa;
        step(0, 1, 0, 0, 0, 0);
        chk("t3_step_1024", (pa - prev + P_MOD) % P_MOD, 1024);

        // valid held while pending: only first config commits; then freeze
        step(0, 1, 1, 24'h080000, 7, 0);
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 1, 1, 24'h400000, 99, 0);
            if (apply) seen = 1;
        end
        chk("t4_apply_seen", seen, 1);
        idle(1);
        chk("t4_offset", (pb - pa + P_MOD) % P_MOD, 7);
        prev = pa;
        idle(1);
        chk("t4_step_256", (pa - prev + P_MOD) % P_MOD, 256);
        fa = pa; fb = pb;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk("t4_frz_pa", pa, fa);
            chk("t4_frz_pb", pb, fb);
            chk("t4_frz_wrap", wrap, 0);
            chk("t4_frz_apply", apply, 0);
        end

        // ftw=0 active: non-sync config commits next enabled cycle
        step(0, 1, 1, 0, 0, 1);
        idle(1);
        chk("t5_sync_apply", apply, 1);
        idle(3);
        chk("t5_frozen_pa", pa, 0);
        step(0, 1, 1, 24'h100000, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("t5_apply", apply, 1);
        idle(1);
        chk("t5_pa", pa, 512);

        // reset while pending discards config
        step(0, 0, 1, 24'h400000, 100, 0);
        chk("t6_ready_pend", ready, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("t6_ready_rst", ready, 1);
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            step(0, 1, 0, 0, 0, 0);
            if (apply) seen = 1;
            chk("t6_pa", pa, (i * 512) % P_MOD);
        end
        chk("t6_no_apply", seen, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [23:0] rf;
            rf = ($urandom_range(0, 9) == 0) ? 24'h0
                                             : 24'($urandom_range(0, 24'h3fffff));
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, 9) == 0,
                 rf,
                 13'($urandom),
                 $urandom_range(0, 9) < 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
